// File: rtl/ibex_pkg.sv
// Shared types for the instruction-fetch front end.
// Fetch request controller state encoding plus address helpers.
package ibex_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_GNT = 1'b1
  } fetch_ctrl_state_e;

  localparam logic [31:0] FETCH_STRIDE = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ibex_fetch_req_tracker.sv
// In-order tracker of granted-but-unanswered fetches; slot 0 is the oldest.
// Same-cycle updates: pop shifts first, branch marks surviving slots, then push fills the lowest free slot.
module ibex_fetch_req_tracker
  import ibex_pkg::*;
#(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic                          push_discard_i,
  input  logic                          pop_i,
  input  logic                          flush_mark_i,
  output logic                          head_valid_o,
  output logic                          head_discard_o,
  output logic [$clog2(NUM_REQS+1)-1:0] count_o
);

  localparam int unsigned CW = $clog2(NUM_REQS + 1);

  logic [NUM_REQS-1:0] r_outst;
  logic [NUM_REQS-1:0] r_discard;
  logic [NUM_REQS-1:0] w_outst_sh;
  logic [NUM_REQS-1:0] w_discard_sh;
  logic [NUM_REQS-1:0] w_outst_nxt;
  logic [NUM_REQS-1:0] w_discard_nxt;
  logic                w_placed;
  logic [CW-1:0]       w_count;

  always_comb begin
    w_outst_sh    = pop_i ? (r_outst >> 1) : r_outst;
    w_discard_sh  = pop_i ? (r_discard >> 1) : r_discard;
    w_outst_nxt   = w_outst_sh;
    // The branch only stales requests already in flight, never the one pushed alongside it.
    w_discard_nxt = w_discard_sh | (flush_mark_i ? w_outst_sh : '0);
    w_placed      = 1'b0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      if (push_i && !w_placed && !w_outst_sh[i]) begin
        w_outst_nxt[i]   = 1'b1;
        w_discard_nxt[i] = push_discard_i;
        w_placed         = 1'b1;
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < int'(NUM_REQS); i++) begin
      w_count = w_count + CW'(r_outst[i]);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_outst   <= '0;
      r_discard <= '0;
    end else begin
      r_outst   <= w_outst_nxt;
      r_discard <= w_discard_nxt;
    end
  end

  assign head_valid_o   = r_outst[0];
  assign head_discard_o = r_discard[0];
  assign count_o        = w_count;

endmodule

// File: rtl/ibex_fetch_req_ctrl.sv
// Issues word-aligned fetches on req/gnt/rvalid and pushes non-stale responses into the fetch FIFO.
// Request and response paths are combinational; requests stall while outstanding + FIFO occupancy reaches NUM_REQS.
module ibex_fetch_req_ctrl
  import ibex_pkg::*;
#(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         addr_i,
  output logic                busy_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_clear_o,
  output logic                fifo_in_valid_o,
  output logic [31:0]         fifo_in_addr_o,
  output logic [31:0]         fifo_in_rdata_o,
  output logic                fifo_in_err_o,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i
);

  localparam int unsigned CW = $clog2(NUM_REQS + 1);
  localparam int unsigned OW = CW + 1;

  fetch_ctrl_state_e r_state;
  fetch_ctrl_state_e w_state_nxt;
  logic [31:0]       r_fetch_addr;
  logic [31:0]       r_pend_addr;
  logic              r_redirect_pend;

  logic [31:0] w_target;
  logic [31:0] w_addr;
  logic        w_req;
  logic        w_grant;
  logic        w_push_discard;
  logic        w_room;
  logic [OW-1:0] w_occ;
  logic [CW-1:0] w_count;
  logic        w_head_valid;
  logic        w_head_discard;

  assign w_target = word_align(addr_i);

  // A branch flushes the FIFO this cycle, so its occupancy no longer limits the new stream.
  always_comb begin
    w_occ = OW'(w_count);
    if (!branch_i) begin
      for (int i = 0; i < int'(NUM_REQS); i++) begin
        w_occ = w_occ + OW'(fifo_busy_i[i]);
      end
    end
  end

  assign w_room = (w_occ < OW'(NUM_REQS)) && (w_count != CW'(NUM_REQS));

  always_comb begin
    w_state_nxt    = r_state;
    w_req          = 1'b0;
    w_addr         = r_pend_addr;
    w_push_discard = 1'b0;
    case (r_state)
      IDLE: begin
        w_addr = branch_i ? w_target : r_fetch_addr;
        w_req  = req_i & w_room;
        if (w_req && !instr_gnt_i) begin
          w_state_nxt = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        w_req          = 1'b1;
        w_push_discard = branch_i | r_redirect_pend;
        if (instr_gnt_i) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_grant = w_req & instr_gnt_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state         <= IDLE;
      r_fetch_addr    <= '0;
      r_pend_addr     <= '0;
      r_redirect_pend <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && w_req && !instr_gnt_i) begin
        r_pend_addr <= w_addr;
      end
      if (w_grant && !w_push_discard) begin
        r_fetch_addr <= w_addr + FETCH_STRIDE;
      end else if (branch_i) begin
        r_fetch_addr <= w_target;
      end
      r_redirect_pend <= (r_state == WAIT_GNT) && !instr_gnt_i && (r_redirect_pend || branch_i);
    end
  end

  ibex_fetch_req_tracker #(
    .NUM_REQS(NUM_REQS)
  ) u_tracker (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .push_i        (w_grant),
    .push_discard_i(w_push_discard),
    .pop_i         (instr_rvalid_i),
    .flush_mark_i  (branch_i),
    .head_valid_o  (w_head_valid),
    .head_discard_o(w_head_discard),
    .count_o       (w_count)
  );

  assign instr_req_o     = w_req & ~rst_i;
  assign instr_addr_o    = rst_i ? '0 : w_addr;
  assign busy_o          = ~rst_i & ((r_state == WAIT_GNT) | (w_count != '0));
  assign fifo_clear_o    = branch_i & ~rst_i;
  assign fifo_in_valid_o = ~rst_i & instr_rvalid_i & ~w_head_discard & ~branch_i;
  assign fifo_in_addr_o  = rst_i ? '0 : addr_i;
  assign fifo_in_rdata_o = rst_i ? '0 : instr_rdata_i;
  assign fifo_in_err_o   = instr_err_i & ~rst_i;

  a_rvalid_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    instr_rvalid_i |-> w_head_valid);
  a_addr_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (instr_req_o && !instr_gnt_i) |=> (instr_req_o && (instr_addr_o == $past(instr_addr_o))));
  a_fifo_space: assert property (@(posedge clk_i) disable iff (rst_i)
    fifo_in_valid_o |-> !fifo_busy_i[NUM_REQS-1]);

endmodule
